// File: rtl/ser_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, break detection and an AXI-Stream
// output FIFO that accepts a simultaneous push and pop even when full.
module ser_uart_rx #(
    parameter int FIFO_DEPTH = 16,
    parameter bit RX_INVERT  = 1'b0,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ser_rx,
    input  logic [15:0]   baud_div,
    output logic [7:0]    m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          frame_err,
    output logic          overflow,
    output logic [AW:0]   fifo_level
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic [1:0]    settle;
    logic          armed;
    logic          rx_s;
    logic [15:0]   div_eff;
    logic [15:0]   div_q;
    logic [15:0]   cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    mem [FIFO_DEPTH];

    assign rx_s    = sync[1] ^ RX_INVERT;
    assign div_eff = (baud_div < 16'd4) ? 16'd4 : baud_div;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync <= 2'b11;
        else         sync <= {sync[0], ser_rx};
    end

    // Start detection waits until the synchroniser holds real line data and the
    // line has been seen idle, so a reset in mid-frame needs a fresh falling edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            div_q     <= 16'd4;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            settle    <= '0;
            armed     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            settle    <= {settle[0], 1'b1};
            if (settle[1] && rx_s) armed <= 1'b1;
            unique case (state)
                S_IDLE: if (armed && !rx_s) begin
                    state <= S_START;
                    div_q <= div_eff;
                    cnt   <= (div_eff >> 1) - 16'd1;
                end
                S_START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state   <= S_DATA;
                            cnt     <= div_q - 16'd1;
                            bit_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else cnt <= cnt - 16'd1;
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        cnt     <= div_q - 16'd1;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_STOP;
                    end else cnt <= cnt - 16'd1;
                end
                S_STOP: begin
                    if (cnt == '0) begin
                        if (rx_s) state <= S_IDLE;
                        else begin
                            state     <= S_BREAK;
                            frame_err <= 1'b1;
                        end
                    end else cnt <= cnt - 16'd1;
                end
                S_BREAK: if (rx_s) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign push  = (state == S_STOP) && (cnt == '0) && rx_s;
    assign pop   = m_axis_tvalid && m_axis_tready;
    assign full  = (fifo_level == (AW+1)'(FIFO_DEPTH));
    // When full, the slot being popped is the one written, so push+pop is safe.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= push && full && !pop;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign m_axis_tvalid = (fifo_level != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : 8'h00;

endmodule

// File: doc/ser_uart_rx.md
SER_UART_RX -- requirements
Module: ser_uart_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO depth in bytes (power of 2, 4..256).
REQ-002 SHALL have parameter RX_INVERT, default 0; 1 = invert ser_rx after synchronisation (inverting level translator).
REQ-003 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port ser_rx  in  1  asynchronous serial line, idle high after optional inversion.
REQ-006 SHALL have port baud_div  in  16  clk cycles per bit.
REQ-007 SHALL have port m_axis_tdata  out  8  received byte.
REQ-008 SHALL have port m_axis_tvalid  out  1  byte available.
REQ-009 SHALL have port m_axis_tready  in  1  consumer accept.
REQ-010 SHALL have port frame_err  out  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port fifo_level  out  log2(FIFO_DEPTH)+1  bytes held.

Function
REQ-013 SHALL pass ser_rx through a 2-flop synchroniser (reset to 1), then apply RX_INVERT; the result is rx_s.
REQ-014 SHALL use an effective divisor div = max(baud_div, 4), latched at start-bit detection and held constant for the whole frame.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: on the first cycle with rx_s = 0, SHALL go to START and load the bit counter with div/2 - 1 (floor).
REQ-017 START: at counter expiry, SHALL sample rx_s; 0 -> DATA with counter = div - 1; 1 -> IDLE (glitch, no error, no output).
REQ-018 DATA: SHALL sample rx_s every div cycles, 8 samples, LSB first, then go to STOP with counter = div - 1.
REQ-019 STOP: at counter expiry with rx_s = 1, SHALL push the byte to the FIFO and return to IDLE in the same edge.
REQ-020 STOP: at counter expiry with rx_s = 0, SHALL discard the byte, pulse frame_err on the next cycle, and enter BREAK.
REQ-021 BREAK: SHALL remain in BREAK until rx_s = 1, then go to IDLE; no start detection while in BREAK.
REQ-022 FIFO push and pop SHALL both be accepted in the same cycle, including when the FIFO is full; level is then unchanged.
REQ-023 A push with FIFO full and no pop in the same cycle SHALL drop the byte, pulse overflow on the next cycle, and leave FIFO contents intact.
REQ-024 m_axis_tvalid SHALL be high iff fifo_level != 0; tdata SHALL be the oldest byte; a pop occurs iff tvalid & tready.
REQ-025 tdata SHALL hold steady while tvalid = 1 and tready = 0.
REQ-026 A push into an empty FIFO SHALL make tvalid high on the cycle after the stop-bit sample edge (latency 1).
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL reach FIFO_DEPTH exactly when full.
REQ-028 A baud_div change mid-frame SHALL NOT affect the current frame; it takes effect from the next start bit.

Reset
REQ-029 While resetn = 0: state = IDLE, FIFO empty, fifo_level = 0, tvalid = 0, tdata = 0, frame_err = 0, overflow = 0, synchroniser = 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no push and no error pulse; after release the block SHALL wait for a fresh high-to-low edge.

Verification
REQ-031 baud_div=8, RX_INVERT=0, send 0xA5 (8N1), tready=1 -> exactly one beat tdata=0xA5, frame_err=0.
REQ-032 baud_div=16, low glitch of 5 cycles on an idle line -> no output, no frame_err, state back to IDLE.
REQ-033 baud_div=8, send 0x3C with stop bit = 0, line held low 40 cycles then high, then send 0x55 -> one frame_err pulse, 0x3C dropped, 0x55 delivered.
REQ-034 FIFO_DEPTH=16, tready=0, send 17 bytes 0x00..0x10 -> fifo_level=16, one overflow pulse on byte 0x10; with tready=1, reads 0x00..0x0F in order.
REQ-035 FIFO full, tready=1 during the stop-bit sample of a new byte -> no overflow, level stays 16, new byte appended last.
REQ-036 RX_INVERT=1, baud_div=2 (clamped to 4), inverted 0x81 -> tdata=0x81; reset mid-byte -> no output, next byte received correctly.
